// File: rtl/div_sched_pkg.sv
// Shared widths, divider latency, divide-by-zero result constants and the
// in-flight tag record for the divider scheduler.
package div_sched_pkg;

    localparam int DIV_A_W  = 8;
    localparam int DIV_B_W  = 5;
    localparam int DIV_LAT  = 7;
    localparam int TAG_ID_W = 3;   // wide enough for up to 8 requesters

    localparam logic [DIV_A_W-1:0] DZ_Q = 8'hFF;
    localparam logic [DIV_B_W-1:0] DZ_R = 5'h00;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                dz;
    } tag_t;

endpackage

// File: rtl/div_sched_rr_arb.sv
// Round-robin arbiter: the first request at or after ptr wins, and the next
// pointer is the slot just after the winner (holds when nothing is granted).
module rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] ptr_nxt,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        any     = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            // one spare bit so the wrap works for non-power-of-two N
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                any      = 1'b1;
                ptr_nxt  = (idx == IW'(N-1)) ? '0 : idx + IW'(1);
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// Shares one pipelined divider among N_REQ requesters: round-robin issue,
// per-requester outstanding limit, tag pipeline matched to divider latency.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LAT     = DIV_LAT,
    parameter int MAX_OUT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [DIV_A_W*N_REQ-1:0]   i_req_a,
    input  logic [DIV_B_W*N_REQ-1:0]   i_req_b,
    output logic [N_REQ-1:0]           o_req_ready,
    output logic                       o_div_valid,
    output logic [DIV_A_W-1:0]         o_div_a,
    output logic [DIV_B_W-1:0]         o_div_b,
    input  logic                       i_div_valid,
    input  logic [DIV_A_W-1:0]         i_div_q,
    input  logic [DIV_B_W-1:0]         i_div_r,
    output logic                       o_rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   o_rsp_id,
    output logic [DIV_A_W-1:0]         o_rsp_q,
    output logic [DIV_B_W-1:0]         o_rsp_r,
    output logic                       o_rsp_dz,
    output logic                       o_err
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [N_REQ-1:0]   elig, gnt, rsp_dec;
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_id;
    logic [DIV_A_W-1:0] gnt_a, iss_a;
    logic [DIV_B_W-1:0] gnt_b, iss_b;
    logic [CNT_W-1:0]   cnt [N_REQ];
    tag_t               tag [0:LAT];
    tag_t               head;
    logic               err_cond;

    assign head = tag[LAT];

    // A returning response frees its slot in the same cycle it is seen.
    always_comb begin
        rsp_dec = '0;
        elig    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rsp_dec[k] = head.valid && (int'(head.id) == k);
            elig[k]    = i_req_valid[k] && !rst &&
                         ((cnt[k] < CNT_W'(MAX_OUT)) || rsp_dec[k]);
        end
    end

    rr_arb #(.N(N_REQ)) u_arb (
        .req     (elig),
        .ptr     (ptr),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt),
        .any     (gnt_any)
    );

    assign o_req_ready = gnt;

    always_comb begin
        gnt_id = '0;
        gnt_a  = '0;
        gnt_b  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                gnt_id = ID_W'(k);
                gnt_a  = i_req_a[DIV_A_W*k +: DIV_A_W];
                gnt_b  = i_req_b[DIV_B_W*k +: DIV_B_W];
            end
        end
    end

    // tag[0] is the issue slot; a zero divisor keeps its slot but never reaches the divider
    assign o_div_valid = tag[0].valid && !tag[0].dz;
    assign o_div_a     = iss_a;
    assign o_div_b     = iss_b;

    always_comb begin
        o_rsp_valid = head.valid;
        o_rsp_id    = '0;
        o_rsp_q     = '0;
        o_rsp_r     = '0;
        o_rsp_dz    = 1'b0;
        if (head.valid) begin
            o_rsp_id = head.id[ID_W-1:0];
            o_rsp_dz = head.dz;
            o_rsp_q  = head.dz ? DZ_Q : i_div_q;
            o_rsp_r  = head.dz ? DZ_R : i_div_r;
        end
    end

    assign err_cond = (head.valid && !head.dz) ? !i_div_valid : i_div_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            iss_a <= '0;
            iss_b <= '0;
            o_err <= 1'b0;
            for (int i = 0; i <= LAT; i++) begin
                tag[i] <= '0;
            end
            for (int k = 0; k < N_REQ; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            if (gnt_any) begin
                ptr <= ptr_nxt;
            end
            tag[0].valid <= gnt_any;
            tag[0].id    <= TAG_ID_W'(gnt_id);
            tag[0].dz    <= gnt_any && (gnt_b == '0);
            iss_a        <= (gnt_any && gnt_b != '0) ? gnt_a : '0;
            iss_b        <= (gnt_any && gnt_b != '0) ? gnt_b : '0;
            for (int i = 1; i <= LAT; i++) begin
                tag[i] <= tag[i-1];
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (gnt[k] && !rsp_dec[k]) begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end else if (!gnt[k] && rsp_dec[k]) begin
                    cnt[k] <= cnt[k] - CNT_W'(1);
                end
            end
            if (err_cond) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: behavioural divider, queue-based reference model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_div_sched;

    localparam int N_REQ   = 4;
    localparam int LAT     = 7;
    localparam int MAX_OUT = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_REQ-1:0]     req_valid;
    logic [8*N_REQ-1:0]   req_a;
    logic [5*N_REQ-1:0]   req_b;
    logic [N_REQ-1:0]     req_ready;
    logic                 div_in_valid;
    logic [7:0]           div_in_a;
    logic [4:0]           div_in_b;
    logic                 div_valid;
    logic [7:0]           div_q;
    logic [4:0]           div_r;
    logic                 rsp_valid;
    logic [1:0]           rsp_id;
    logic [7:0]           rsp_q;
    logic [4:0]           rsp_r;
    logic                 rsp_dz;
    logic                 err;
    logic                 inject = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_sched #(.N_REQ(N_REQ), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_ready (req_ready),
        .o_div_valid (div_in_valid),
        .o_div_a     (div_in_a),
        .o_div_b     (div_in_b),
        .i_div_valid (div_valid),
        .i_div_q     (div_q),
        .i_div_r     (div_r),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_q     (rsp_q),
        .o_rsp_r     (rsp_r),
        .o_rsp_dz    (rsp_dz),
        .o_err       (err)
    );

    // Behavioural pipelined divider sharing rst.
    logic [LAT-1:0] dv;
    logic [7:0]     dq [LAT];
    logic [4:0]     dr [LAT];

    always @(posedge clk) begin
        if (rst) begin
            dv <= '0;
            for (int i = 0; i < LAT; i++) begin
                dq[i] <= '0;
                dr[i] <= '0;
            end
        end else begin
            dv    <= {dv[LAT-2:0], div_in_valid};
            dq[0] <= (div_in_b != 0) ? div_in_a / {3'b000, div_in_b} : 8'h00;
            dr[0] <= (div_in_b != 0) ? 5'(div_in_a % {3'b000, div_in_b}) : 5'h00;
            for (int i = 1; i < LAT; i++) begin
                dq[i] <= dq[i-1];
                dr[i] <= dr[i-1];
            end
        end
    end

    assign div_valid = dv[LAT-1] | inject;
    assign div_q     = dq[LAT-1];
    assign div_r     = dr[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: outstanding counts, pointer, queue of expected responses.
    typedef struct {
        int id;
        int q;
        int r;
        bit dz;
        int due;
    } exp_t;

    exp_t             eq[$];
    exp_t             e;
    int               m_cnt [N_REQ];
    int               m_ptr = 0;
    bit               m_err = 0;
    bit               ei_v = 0;
    int               ei_a = 0;
    int               ei_b = 0;
    bit               exp_rv;
    bit [N_REQ-1:0]   m_elig;
    int               win;
    int               ga, gb;

    always @(negedge clk) begin
        if (rst) begin
            check("ready_in_rst", 32'(req_ready), 32'd0);
            eq.delete();
            for (int k = 0; k < N_REQ; k++) m_cnt[k] = 0;
            m_ptr = 0;
            m_err = 0;
            ei_v  = 0;
            ei_a  = 0;
            ei_b  = 0;
        end else begin
            exp_rv = (eq.size() > 0) && (eq[0].due == cyc);
            if (exp_rv) begin
                check("rsp_valid", 32'(rsp_valid), 32'd1);
                check("rsp_id", 32'(rsp_id), 32'(eq[0].id));
                check("rsp_q", 32'(rsp_q), 32'(eq[0].q));
                check("rsp_r", 32'(rsp_r), 32'(eq[0].r));
                check("rsp_dz", 32'(rsp_dz), 32'(eq[0].dz));
            end else begin
                check("rsp_idle", {rsp_valid, rsp_dz, 3'b0, rsp_r, rsp_q, 6'b0, rsp_id}, 32'd0);
            end

            for (int k = 0; k < N_REQ; k++) begin
                m_elig[k] = req_valid[k] &&
                            ((m_cnt[k] < MAX_OUT) || (exp_rv && eq[0].id == k));
            end
            win = -1;
            for (int i = 0; i < N_REQ; i++) begin
                if (win < 0 && m_elig[(m_ptr + i) % N_REQ]) win = (m_ptr + i) % N_REQ;
            end
            check("req_ready", 32'(req_ready), (win < 0) ? 32'd0 : (32'd1 << win));

            check("div_valid", 32'(div_in_valid), 32'(ei_v));
            check("div_a", 32'(div_in_a), 32'(ei_a));
            check("div_b", 32'(div_in_b), 32'(ei_b));
            check("err", 32'(err), 32'(m_err));

            if (inject && !(exp_rv && !eq[0].dz)) m_err = 1;
            if (exp_rv) begin
                m_cnt[eq[0].id]--;
                void'(eq.pop_front());
            end
            if (win >= 0) begin
                ga = int'(req_a[8*win +: 8]);
                gb = int'(req_b[5*win +: 5]);
                m_cnt[win]++;
                m_ptr = (win + 1) % N_REQ;
                e.id  = win;
                e.dz  = (gb == 0);
                e.q   = (gb == 0) ? 255 : ga / gb;
                e.r   = (gb == 0) ? 0 : ga % gb;
                e.due = cyc + 1 + LAT;
                eq.push_back(e);
                ei_v = (gb != 0);
                ei_a = (gb != 0) ? ga : 0;
                ei_b = (gb != 0) ? gb : 0;
            end else begin
                ei_v = 0;
                ei_a = 0;
                ei_b = 0;
            end
        end
    end

    task automatic clr_inputs();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic set_req(input int k, input logic [7:0] a, input logic [4:0] b);
        req_valid[k]    = 1'b1;
        req_a[8*k +: 8] = a;
        req_b[5*k +: 5] = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            next_cycle();
            clr_inputs();
        end
    endtask

    task automatic do_reset();
        next_cycle();
        clr_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clr_inputs();
        rst = 1'b1;
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset_div_valid", 32'(div_in_valid), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        // single op: 200 / 7 from requester 2
        next_cycle(); set_req(2, 8'd200, 5'd7);
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'b0100);
        next_cycle(); clr_inputs();
        @(negedge clk);
        check("single_issue_v", 32'(div_in_valid), 32'd1);
        check("single_issue_a", 32'(div_in_a), 32'd200);
        check("single_issue_b", 32'(div_in_b), 32'd7);
        idle(6);
        next_cycle();
        @(negedge clk);
        check("single_rsp_v", 32'(rsp_valid), 32'd1);
        check("single_rsp_id", 32'(rsp_id), 32'd2);
        check("single_rsp_q", 32'(rsp_q), 32'd28);
        check("single_rsp_r", 32'(rsp_r), 32'd4);
        check("single_rsp_dz", 32'(rsp_dz), 32'd0);
        idle(4);

        // all requesters continuously
        do_reset();
        for (int t = 0; t < 16; t++) begin
            next_cycle();
            for (int k = 0; k < N_REQ; k++) set_req(k, 8'(50 + 37 * k), 5'(k + 3));
            @(negedge clk);
            if (t < 4) check("rr_ready", 32'(req_ready), 32'd1 << t);
            if (t >= 8 && t < 12) begin
                check("rr_rsp_v", 32'(rsp_valid), 32'd1);
                check("rr_rsp_id", 32'(rsp_id), 32'(t - 8));
            end
            if (t == 8) begin
                check("rr_rsp_q0", 32'(rsp_q), 32'd16);
                check("rr_rsp_r0", 32'(rsp_r), 32'd2);
            end
        end
        idle(12);

        // divide by zero from requester 1
        next_cycle(); set_req(1, 8'd55, 5'd0);
        @(negedge clk);
        check("dz_ready", 32'(req_ready), 32'b0010);
        next_cycle(); clr_inputs();
        @(negedge clk);
        check("dz_issue_v", 32'(div_in_valid), 32'd0);
        idle(6);
        next_cycle();
        @(negedge clk);
        check("dz_rsp_v", 32'(rsp_valid), 32'd1);
        check("dz_rsp_id", 32'(rsp_id), 32'd1);
        check("dz_rsp_q", 32'(rsp_q), 32'hFF);
        check("dz_rsp_r", 32'(rsp_r), 32'h00);
        check("dz_rsp_dz", 32'(rsp_dz), 32'd1);
        idle(2);
        @(negedge clk);
        check("dz_no_err", 32'(err), 32'd0);

        // outstanding limit on requester 0
        for (int t = 0; t < 10; t++) begin
            next_cycle(); clr_inputs(); set_req(0, 8'd100, 5'd9);
            @(negedge clk);
            if (t <= 8) check("limit_ready0", 32'(req_ready[0]), (t < 3 || t == 8) ? 32'd1 : 32'd0);
        end
        idle(12);

        // reset while three ops are in flight
        next_cycle(); clr_inputs(); set_req(1, 8'd90, 5'd4);
        next_cycle(); clr_inputs(); set_req(2, 8'd91, 5'd5);
        next_cycle(); clr_inputs(); set_req(2, 8'd92, 5'd6);
        next_cycle(); clr_inputs();
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0;
        for (int t = 0; t < 12; t++) begin
            next_cycle();
            @(negedge clk);
            check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end
        next_cycle();
        for (int k = 0; k < N_REQ; k++) set_req(k, 8'(10 + k), 5'd3);
        @(negedge clk);
        check("ptr_after_rst", 32'(req_ready), 32'b0001);
        idle(12);

        // stray divider valid with an empty head
        next_cycle(); clr_inputs(); inject = 1'b1;
        @(negedge clk);
        check("inj_err_before", 32'(err), 32'd0);
        next_cycle(); inject = 1'b0;
        @(negedge clk);
        check("inj_err_set", 32'(err), 32'd1);
        idle(5);
        @(negedge clk);
        check("inj_err_sticky", 32'(err), 32'd1);
        do_reset();
        @(negedge clk);
        check("inj_err_clear", 32'(err), 32'd0);

        // random traffic
        for (int t = 0; t < 600; t++) begin
            next_cycle();
            for (int k = 0; k < N_REQ; k++) begin
                if ($urandom_range(99) < 60) set_req(k, 8'($urandom), 5'($urandom_range(31)));
                else req_valid[k] = 1'b0;
            end
        end
        idle(12);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_sched.md
# div_sched

Round-robin scheduler that shares one pipelined 8-bit / 5-bit divider among several requesters. It arbitrates one request per cycle into the divider and tracks each in-flight operation with a tag shift register matched to the divider latency. Results are returned with the requester ID. Divide-by-zero is screened and forced to a defined result. The block sits between the client blocks and the divider, which has no stall input.

## Interface
- N_REQ, 4, number of requesters (2..8)
- LAT, 7, divider input-to-output latency in cycles
- MAX_OUT, 3, maximum in-flight operations per requester

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- i_req_valid  in  N_REQ  request valid per requester
- i_req_a  in  8*N_REQ  dividend, requester k at [8k+7:8k]
- i_req_b  in  5*N_REQ  divisor, requester k at [5k+4:5k]
- o_req_ready  out  N_REQ  grant; request k is accepted when valid[k] & ready[k]
- o_div_valid  out  1  divider input valid
- o_div_a  out  8  divider dividend
- o_div_b  out  5  divider divisor
- i_div_valid  in  1  divider output valid
- i_div_q  in  8  divider quotient
- i_div_r  in  5  divider remainder
- o_rsp_valid  out  1  response valid, single-cycle, no backpressure
- o_rsp_id  out  clog2(N_REQ)  requester ID of the response
- o_rsp_q  out  8  quotient
- o_rsp_r  out  5  remainder
- o_rsp_dz  out  1  response was a divide-by-zero
- o_err  out  1  sticky: i_div_valid disagreed with the tag pipeline

## Operation
- Eligibility: requester k is eligible when i_req_valid[k] is high and cnt[k] < MAX_OUT.
- Arbitration: round-robin starting from ptr. The first eligible requester at or after ptr wins.
  - At most one ready bit is high per cycle.
  - ready is combinational from valid, cnt and ptr.
- Pointer update: on a grant to k, ptr ← (k+1) mod N_REQ. With no grant, ptr holds.
- Issue: the grant is registered. The next cycle drives o_div_valid=1, o_div_a, o_div_b. With no grant, o_div_valid=0 and o_div_a/b=0.
- Tag pipeline: LAT+1 entries, each {valid, id, dz}. The tag is loaded in the issue cycle and shifts every cycle.
- Divide-by-zero: b==0 is still granted and occupies its tag slot.
  - o_div_valid=0 for that slot, with dz=1 in the tag.
  - Response: q=8'hFF, r=5'h00, o_rsp_dz=1.
- Response: driven combinationally from the tag head, in the cycle the head is valid.
  - o_rsp_q/r come from i_div_q/r, or from the dz constants.
  - When the head is not valid, o_rsp_valid=0 and the data outputs are 0.
- Counters: cnt[k] increments on grant to k and decrements on response with id k. Both in one cycle leaves it unchanged.
- Error check: o_err sets when the head is valid with dz=0 and i_div_valid=0, or when the head is not valid or dz=1 and i_div_valid=1. It is cleared only by rst.

## Timing
- Reset values:
  - o_req_ready=0 during rst.
  - o_div_valid=0, o_rsp_valid=0, o_err=0.
  - All tags invalid, all cnt=0, ptr=0.
- Latency: request accepted in cycle t → o_div_valid in t+1 → o_rsp_valid in t+1+LAT (t+8 at default).
- Throughput: one accept per cycle in aggregate, one response per cycle.
- Responses return in grant order.
- Reset mid-operation: all in-flight tags are discarded and no responses are produced for them.
  - The divider shares rst, so stale i_div_valid does not occur.
  - Any stale i_div_valid after reset sets o_err.
- Full: a requester with cnt==MAX_OUT is skipped and ptr skips past it. The response that decrements cnt makes it eligible in the same cycle.
- Wrap-around: ptr wraps from N_REQ-1 to 0. With a single eligible requester, it is granted every cycle until MAX_OUT.

## Structure
- A shared package holds:
  - DIV_A_W=8, DIV_B_W=5, DIV_LAT=7.
  - The dz constants DZ_Q=8'hFF and DZ_R=5'h00.
  - The tag struct {valid, id, dz}.
- One sub-module, rr_arb: a parameterised round-robin arbiter (request vector, pointer → one-hot grant, next pointer).
- Tag pipeline, counters and response mux stay in div_sched.

## Test plan
- Single op: requester 2 sends a=200, b=7 at t=0 → o_div_valid at t=1 → o_rsp_valid at t=8 with id=2, q=28, r=4, dz=0.
- All 4 requesters valid continuously with distinct operands:
  - Grants in order 0,1,2,3,0,…
  - Responses in the same order, one per cycle from t=8.
  - Every q/r matches a/b and a%b.
- Divide-by-zero: requester 1 sends a=55, b=0 → o_div_valid=0 in the issue cycle → response at t+8 with q=FF, r=00, dz=1, id=1, and o_err stays 0.
- Outstanding limit: requester 0 alone, valid for 10 cycles:
  - Accepted at t=0,1,2; ready=0 for t=3..7.
  - Accepted again at t=8, the cycle its first response returns.
- Reset mid-flight: issue 3 ops, assert rst for 1 cycle at t=4 → no o_rsp_valid afterwards, cnt=0, and ptr=0 (next grant goes to requester 0 first).
- Error injection: force i_div_valid=1 in a cycle with an empty tag head → o_err=1, held until rst.
